// File: rtl/sram_dp_pwr.sv
// sram_dp_pwr: dual-port synchronous SRAM with an automatic retention/sleep
// power controller. Both ports share one clock. An access is accepted when
// CENx=0 and RDYx=1. After IDLE_CYCLES consecutive idle cycles the array drops
// into retention (RET1N=0). The first request seen afterwards wakes the array,
// and the client holds that request until RDY returns.
//
// Ports:
//   clk, rst            shared clock, synchronous active-high reset
//   CENA/CENB           chip enable, active low
//   WENA/WENB           write enable, active low (0 = write, 1 = read)
//   AA/AB, DA/DB        address and write data
//   RDYA/RDYB           registered ready; always equal to each other
//   QA/QB, VALIDA/B     read data and one-cycle "new data" strobe
//   COLL                one-cycle pulse after a same-address write/write
//   RET1N               retention control to the array, active low
//
// Optional feature macro: SRAM_DP_PWR_OUT_REG_EN adds an output register stage
// on QA/QB/VALIDA/VALIDB/COLL, which makes the read latency 2 cycles.
module sram_dp_pwr #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned BITS        = 32,
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CENA,
  input  logic                  WENA,
  input  logic [ADDR_WIDTH-1:0] AA,
  input  logic [BITS-1:0]       DA,
  input  logic                  CENB,
  input  logic                  WENB,
  input  logic [ADDR_WIDTH-1:0] AB,
  input  logic [BITS-1:0]       DB,
  output logic                  RDYA,
  output logic                  RDYB,
  output logic [BITS-1:0]       QA,
  output logic [BITS-1:0]       QB,
  output logic                  VALIDA,
  output logic                  VALIDB,
  output logic                  COLL,
  output logic                  RET1N
);

  localparam int unsigned DEPTH     = 2**ADDR_WIDTH;
  localparam int unsigned IDLE_W    = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int unsigned WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES + 1) : 1;
  localparam int unsigned IDLE_LAST = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  // A WAKE_CYCLES of 0 is treated as the minimum of one wake cycle.
  localparam int unsigned WAKE_LAST = (WAKE_CYCLES > 1) ? WAKE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [WAKE_W-1:0]   wake_q, wake_d;
  logic                rdy_q, rdy_d;
  logic                ret1n_q, ret1n_d;

  logic [BITS-1:0]     mem [DEPTH];

  logic                any_req;
  logic                acc_a, acc_b;
  logic                wr_a, wr_b, rd_a, rd_b;
  logic                ww_coll;
  logic                pipe_empty;

  logic [BITS-1:0]     q_a, q_b;
  logic                v_a, v_b;
  logic                coll_r;

  assign any_req = !CENA || !CENB;
  assign acc_a   = !CENA && rdy_q;
  assign acc_b   = !CENB && rdy_q;
  assign wr_a    = acc_a && !WENA;
  assign wr_b    = acc_b && !WENB;
  assign rd_a    = acc_a && WENA;
  assign rd_b    = acc_b && WENB;
  assign ww_coll = wr_a && wr_b && (AA == AB);

  // Power FSM state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
      rdy_q   <= 1'b1;
      ret1n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
      rdy_q   <= rdy_d;
      ret1n_q <= ret1n_d;
    end
  end

  // Next-state logic; RDY/RET1N are registered from the next state so that
  // they carry no combinational path from CENx.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    unique case (state_q)
      ST_ACTIVE: begin
        wake_d = '0;
        if (any_req) begin
          idle_d = '0;
        end else if ((IDLE_CYCLES != 0) && (idle_q >= IDLE_W'(IDLE_LAST)) && pipe_empty) begin
          state_d = ST_SLEEP;
          idle_d  = '0;
        end else if (idle_q != IDLE_W'(IDLE_CYCLES)) begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_SLEEP: begin
        wake_d = '0;
        if (any_req) begin
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (wake_q >= WAKE_W'(WAKE_LAST)) begin
          state_d = ST_ACTIVE;
          idle_d  = '0;
          wake_d  = '0;
        end else begin
          wake_d = wake_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
        idle_d  = '0;
        wake_d  = '0;
      end
    endcase
    rdy_d   = (state_d == ST_ACTIVE);
    ret1n_d = (state_d != ST_SLEEP);
  end

  // Array writes; port A wins a same-address write/write
  always_ff @(posedge clk) begin
    if (wr_a) begin
      mem[AA] <= DA;
    end
    if (wr_b && !ww_coll) begin
      mem[AB] <= DB;
    end
  end

  // Read capture sees pre-write contents, so a same-cycle reader returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      q_a    <= '0;
      q_b    <= '0;
      v_a    <= 1'b0;
      v_b    <= 1'b0;
      coll_r <= 1'b0;
    end else begin
      v_a    <= rd_a;
      v_b    <= rd_b;
      coll_r <= ww_coll;
      if (rd_a) begin
        q_a <= mem[AA];
      end
      if (rd_b) begin
        q_b <= mem[AB];
      end
    end
  end

`ifdef SRAM_DP_PWR_OUT_REG_EN
  logic [BITS-1:0] q_a2, q_b2;
  logic            v_a2, v_b2;
  logic            coll2;

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      q_a2  <= '0;
      q_b2  <= '0;
      v_a2  <= 1'b0;
      v_b2  <= 1'b0;
      coll2 <= 1'b0;
    end else begin
      q_a2  <= q_a;
      q_b2  <= q_b;
      v_a2  <= v_a;
      v_b2  <= v_b;
      coll2 <= coll_r;
    end
  end

  assign QA     = q_a2;
  assign QB     = q_b2;
  assign VALIDA = v_a2;
  assign VALIDB = v_b2;
  assign COLL   = coll2;
  // Hold off retention while a result is still travelling to the outputs
  assign pipe_empty = !(v_a || v_b || coll_r);
`else
  assign QA     = q_a;
  assign QB     = q_b;
  assign VALIDA = v_a;
  assign VALIDB = v_b;
  assign COLL   = coll_r;
  assign pipe_empty = 1'b1;
`endif

  assign RDYA  = rdy_q;
  assign RDYB  = rdy_q;
  assign RET1N = ret1n_q;

endmodule

// File: tb/tb_sram_dp_pwr.sv
// Scoreboard bench for sram_dp_pwr: the driver applies requests and pushes
// expected reads/collisions from a reference model; a monitor pops on outputs.
module tb_sram_dp_pwr;

  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned IDLE = 8;
  localparam int unsigned WAKE = 3;
`ifdef SRAM_DP_PWR_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int M_ACT = 0;
  localparam int M_SLP = 1;
  localparam int M_WK  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          CENA, WENA, CENB, WENB;
  logic [AW-1:0] AA, AB;
  logic [DW-1:0] DA, DB;
  logic          RDYA, RDYB, VALIDA, VALIDB, COLL, RET1N;
  logic [DW-1:0] QA, QB;

  sram_dp_pwr #(
    .ADDR_WIDTH (AW),
    .BITS       (DW),
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .CENA  (CENA),
    .WENA  (WENA),
    .AA    (AA),
    .DA    (DA),
    .CENB  (CENB),
    .WENB  (WENB),
    .AB    (AB),
    .DB    (DB),
    .RDYA  (RDYA),
    .RDYB  (RDYB),
    .QA    (QA),
    .QB    (QB),
    .VALIDA(VALIDA),
    .VALIDB(VALIDB),
    .COLL  (COLL),
    .RET1N (RET1N)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            en;
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  // Reference model state
  logic [DW-1:0] mm [2**AW];
  bit            written [2**AW];
  int            m_mode    = M_ACT;
  int            idle_run  = 0;
  int            wake_left = 0;
  bit            acc_a, acc_b;

  exp_t          qa_q[$];
  exp_t          qb_q[$];
  int            coll_q[$];
  logic [DW-1:0] last_qa = '0;
  logic [DW-1:0] last_qb = '0;

  int            mcyc     = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  function automatic req_t none();
    req_t r;
    r.en = 1'b0;
    r.wr = 1'b0;
    r.a  = '0;
    r.d  = '0;
    return r;
  endfunction

  function automatic req_t rd(input int unsigned a);
    req_t r;
    r.en = 1'b1;
    r.wr = 1'b0;
    r.a  = AW'(a);
    r.d  = '0;
    return r;
  endfunction

  function automatic req_t wr(input int unsigned a, input logic [DW-1:0] d);
    req_t r;
    r.en = 1'b1;
    r.wr = 1'b1;
    r.a  = AW'(a);
    r.d  = d;
    return r;
  endfunction

  function automatic req_t gen();
    req_t r;
    r.en = ($urandom_range(0, 9) < 6);
    r.wr = 1'($urandom_range(0, 1));
    r.a  = AW'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) r.a = AW'($urandom);
    r.d  = $urandom;
    if (!r.wr && !written[r.a]) r.wr = 1'b1;
    return r;
  endfunction

  task automatic check_power();
    chk("RDYA", 32'(RDYA), 32'(m_mode == M_ACT));
    chk("RDYB", 32'(RDYB), 32'(m_mode == M_ACT));
    chk("RET1N", 32'(RET1N), 32'(m_mode != M_SLP));
  endtask

  // One clock of stimulus plus the matching model update
  task automatic step(input req_t ra, input req_t rb);
    bit   req;
    bit   ok;
    exp_t e;
    @(negedge clk);
    check_power();
    rst  = 1'b0;
    CENA = !ra.en;
    WENA = !ra.wr;
    AA   = ra.a;
    DA   = ra.d;
    CENB = !rb.en;
    WENB = !rb.wr;
    AB   = rb.a;
    DB   = rb.d;

    req   = ra.en || rb.en;
    ok    = (m_mode == M_ACT);
    acc_a = ra.en && ok;
    acc_b = rb.en && ok;
    if (acc_a && !ra.wr) begin
      e.due = mcyc + LAT; e.data = mm[ra.a]; qa_q.push_back(e);
    end
    if (acc_b && !rb.wr) begin
      e.due = mcyc + LAT; e.data = mm[rb.a]; qb_q.push_back(e);
    end
    if (acc_a && acc_b && ra.wr && rb.wr && ra.a == rb.a) coll_q.push_back(mcyc + LAT);
    // B first so that A overwrites it on a same-address collision
    if (acc_b && rb.wr) begin mm[rb.a] = rb.d; written[rb.a] = 1'b1; end
    if (acc_a && ra.wr) begin mm[ra.a] = ra.d; written[ra.a] = 1'b1; end

    case (m_mode)
      M_ACT: begin
        if (req) idle_run = 0;
        else begin
          idle_run++;
          if (idle_run == int'(IDLE)) begin m_mode = M_SLP; idle_run = 0; end
        end
      end
      M_SLP: if (req) begin m_mode = M_WK; wake_left = int'(WAKE); end
      default: begin
        wake_left--;
        if (wake_left == 0) begin m_mode = M_ACT; idle_run = 0; end
      end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_power();
    rst  = 1'b1;
    CENA = 1'b1;
    CENB = 1'b1;
    qa_q.delete();
    qb_q.delete();
    coll_q.delete();
    last_qa   = '0;
    last_qb   = '0;
    m_mode    = M_ACT;
    idle_run  = 0;
    wake_left = 0;
  endtask

  // Monitor: compares outputs against the scoreboard one step after each edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      mcyc++;
      if (qa_q.size() != 0 && qa_q[0].due == mcyc) begin
        e = qa_q.pop_front();
        chk("VALIDA", 32'(VALIDA), 32'd1);
        if (VALIDA) begin chk("QA", QA, e.data); last_qa = e.data; end
      end else begin
        chk("VALIDA idle", 32'(VALIDA), 32'd0);
        chk("QA hold", QA, last_qa);
      end
      if (qb_q.size() != 0 && qb_q[0].due == mcyc) begin
        e = qb_q.pop_front();
        chk("VALIDB", 32'(VALIDB), 32'd1);
        if (VALIDB) begin chk("QB", QB, e.data); last_qb = e.data; end
      end else begin
        chk("VALIDB idle", 32'(VALIDB), 32'd0);
        chk("QB hold", QB, last_qb);
      end
      if (coll_q.size() != 0 && coll_q[0] == mcyc) begin
        void'(coll_q.pop_front());
        chk("COLL", 32'(COLL), 32'd1);
      end else begin
        chk("COLL idle", 32'(COLL), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached before the end of stimulus");
    $fatal(1, "time limit");
  end

  initial begin : driver
    req_t ra, rb;
    bit   hold_a, hold_b;
    int   idle_left;
    rst  = 1'b1;
    CENA = 1'b1; WENA = 1'b1; AA = '0; DA = '0;
    CENB = 1'b1; WENB = 1'b1; AB = '0; DB = '0;
    repeat (2) @(posedge clk);

    // Cross-port write then read
    step(wr(12'h005, 32'hDEAD_BEEF), none());
    step(none(), rd(12'h005));
    // Write/write collision: A wins
    step(wr(12'h3FF, 32'h1111), wr(12'h3FF, 32'h2222));
    step(rd(12'h3FF), none());
    // Write + read same address returns old data
    step(wr(12'h010, 32'h5555), none());
    step(wr(12'h010, 32'hAAAA), rd(12'h010));
    step(rd(12'h010), rd(12'h010));

    // Sleep entry, then a held read wakes the array
    repeat (IDLE) step(none(), none());
    for (int i = 0; i < 20; i++) begin
      step(rd(12'h005), none());
      if (acc_a) break;
    end

    // Access on the last idle cycle keeps the array active
    repeat (IDLE - 1) step(none(), none());
    step(rd(12'h3FF), none());
    step(none(), none());

    // Reset while waking
    repeat (IDLE) step(none(), none());
    step(rd(12'h010), none());
    step(rd(12'h010), none());
    do_reset();
    step(none(), none());
    step(rd(12'h010), wr(12'h011, 32'h0BAD_F00D));

    // Randomized traffic with idle bursts long enough to trigger sleep
    hold_a = 1'b0;
    hold_b = 1'b0;
    idle_left = 0;
    ra = none();
    rb = none();
    for (int i = 0; i < 3000; i++) begin
      if (!hold_a && !hold_b && idle_left == 0 && $urandom_range(0, 39) == 0)
        idle_left = int'($urandom_range(4, 12));
      if (!hold_a) ra = (idle_left > 0) ? none() : gen();
      if (!hold_b) rb = (idle_left > 0) ? none() : gen();
      if (idle_left > 0) idle_left--;
      step(ra, rb);
      hold_a = ra.en && !acc_a;
      hold_b = rb.en && !acc_b;
    end

    repeat (LAT + 2) step(none(), none());
    chk("outstanding", 32'(qa_q.size() + qb_q.size() + coll_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
